// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and round-robin pick function for mux_rr_arbiter
//
// Purpose : arbiter FSM state enum plus rr_pick(), a rotating-priority
//           first-set-bit search usable for any requester count up to
//           ARB_MAX_REQ.
// Contents: arb_state_t, rr_pick_t, rr_pick()
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // rr_pick works on a fixed-width view so one function serves every NUM_REQ.
  localparam int ARB_MAX_REQ = 32;
  localparam int ARB_IDX_W   = 5;

  typedef struct packed {
    logic                 any;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  // Search ptr, ptr+1, ... wrapping at num_req; first set bit wins.
  // ptr < num_req, so a single conditional subtract implements the wrap.
  function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                       input logic [ARB_IDX_W-1:0]   ptr,
                                       input int                     num_req);
    rr_pick_t res;
    int       cand;
    res.any = 1'b0;
    res.idx = '0;
    for (int off = 0; off < ARB_MAX_REQ; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= num_req) begin
        cand = cand - num_req;
      end
      if ((off < num_req) && !res.any && req[cand]) begin
        res.any = 1'b1;
        res.idx = cand[ARB_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// rtl/mux_nto1.sv - parameterised N:1 combinational data multiplexer
//
// Purpose: selects one DATA_W word out of NUM_REQ packed words.
// Ports  : i_data [NUM_REQ*DATA_W] packed inputs, word i at [i*DATA_W +: DATA_W]
//          i_sel  [SEL_W]          select index
//          o_data [DATA_W]         selected word (0 for an out-of-range index)
module mux_nto1 #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [DATA_W-1:0]         o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_data = i_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one N:1 mux with bounded bursts
//
// Purpose: grants a shared output mux to one requester at a time, holds the
//          grant for at most MAX_HOLD beats, then releases through a one-cycle
//          idle bubble in which the next owner is chosen round-robin.
// Ports  : clk        clock, rising edge
//          rst        synchronous active-high reset
//          req        per-requester request
//          data       packed requester data, requester i at [i*DATA_W +: DATA_W]
//          gnt        registered one-hot grant, zero when idle
//          out_sel    registered index of the granted requester
//          out_data   selected data while granted, else 0
//          out_valid  granted requester is still requesting
//          out_ready  downstream accept
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 8,
  parameter  int MAX_HOLD = 4,
  localparam int SEL_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          out_sel,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_ptr;
  logic [HOLD_W-1:0]   r_beat_cnt;

  arb_state_t          w_state_nxt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic [HOLD_W-1:0]   w_beat_cnt_nxt;

  rr_pick_t            w_pick;
  logic                w_req_sel;
  logic                w_beat;
  logic                w_last_beat;
  logic [SEL_W-1:0]    w_sel_inc;
  logic [DATA_W-1:0]   w_mux_data;

  assign w_pick      = rr_pick(ARB_MAX_REQ'(req), ARB_IDX_W'(r_ptr), NUM_REQ);
  assign w_req_sel   = req[r_sel];
  assign w_beat      = (r_state == GRANT) && w_req_sel && out_ready;
  assign w_last_beat = (r_beat_cnt == HOLD_W'(MAX_HOLD - 1));
  // Explicit wrap so non-power-of-two NUM_REQ never yields an index >= NUM_REQ.
  assign w_sel_inc   = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + SEL_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_sel_nxt      = r_sel;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick.any) begin
          w_state_nxt    = GRANT;
          w_sel_nxt      = SEL_W'(w_pick.idx);
          w_gnt_nxt      = NUM_REQ'(ARB_MAX_REQ'(1) << w_pick.idx);
          w_beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        // Owner dropping its request and a final beat both land here, so a
        // coincident pair is a single release.
        if (!w_req_sel || (w_beat && w_last_beat)) begin
          w_state_nxt    = IDLE;
          w_gnt_nxt      = '0;
          w_ptr_nxt      = w_sel_inc;
          w_beat_cnt_nxt = '0;
        end else if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  mux_nto1 #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) u_mux (
    .i_data (data),
    .i_sel  (r_sel),
    .o_data (w_mux_data)
  );

  assign gnt       = r_gnt;
  assign out_sel   = r_sel;
  assign out_valid = (r_state == GRANT) && w_req_sel;
  assign out_data  = (r_state == GRANT) ? w_mux_data : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req0, req2;
  logic [2:0]  req1;
  logic [31:0] data0, data2;
  logic [23:0] data1;
  logic        rdy0, rdy1, rdy2;

  logic [3:0]  g0, g2;
  logic [2:0]  g1;
  logic [1:0]  sel0, sel1, sel2;
  logic [7:0]  od0, od1, od2;
  logic        ov0, ov1, ov2;

  // inst0: 4 requesters, hold 4; inst1: 3 requesters, hold 4; inst2: 4 requesters, hold 1
  mux_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) u0 (
    .clk(clk), .rst(rst), .req(req0), .data(data0), .gnt(g0), .out_sel(sel0),
    .out_data(od0), .out_valid(ov0), .out_ready(rdy0));
  mux_rr_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_HOLD(4)) u1 (
    .clk(clk), .rst(rst), .req(req1), .data(data1), .gnt(g1), .out_sel(sel1),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1));
  mux_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(1)) u2 (
    .clk(clk), .rst(rst), .req(req2), .data(data2), .gnt(g2), .out_sel(sel2),
    .out_data(od2), .out_valid(ov2), .out_ready(rdy2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural reference: who owns the mux, beats taken, where the search starts.
  bit m_busy [3];
  int m_sel  [3];
  int m_cnt  [3];
  int m_ptr  [3];
  int m_n    [3] = '{4, 3, 4};
  int m_hold [3] = '{4, 4, 1};
  int glog0[$];
  int glog1[$];
  int glog2[$];

  function automatic logic [3:0] req_of(input int k);
    case (k)
      0:       return req0;
      1:       return {1'b0, req1};
      default: return req2;
    endcase
  endfunction

  function automatic logic [7:0] data_of(input int k, input int idx);
    case (k)
      0:       return data0[idx*8 +: 8];
      1:       return data1[idx*8 +: 8];
      default: return data2[idx*8 +: 8];
    endcase
  endfunction

  function automatic logic rdy_of(input int k);
    case (k)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic [3:0] r;
    bit release_now;
    r = req_of(k);
    release_now = 0;
    if (rst) begin
      m_busy[k] = 0; m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
    end else if (!m_busy[k]) begin
      for (int off = 0; off < m_n[k]; off++) begin
        int idx;
        idx = (m_ptr[k] + off) % m_n[k];
        if (!m_busy[k] && r[idx]) begin
          m_busy[k] = 1; m_sel[k] = idx; m_cnt[k] = 0;
          case (k)
            0:       glog0.push_back(idx);
            1:       glog1.push_back(idx);
            default: glog2.push_back(idx);
          endcase
        end
      end
    end else begin
      if (!r[m_sel[k]]) begin
        release_now = 1;
      end else if (rdy_of(k)) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == m_hold[k]) release_now = 1;
      end
      if (release_now) begin
        m_busy[k] = 0;
        m_cnt[k]  = 0;
        m_ptr[k]  = (m_sel[k] + 1) % m_n[k];
      end
    end
  endtask

  task automatic check_inst(input int k);
    logic [3:0] og, eg, r;
    logic [1:0] os;
    logic [7:0] od, ed;
    logic       ov, ev;
    case (k)
      0:       begin og = g0;          os = sel0; od = od0; ov = ov0; end
      1:       begin og = {1'b0, g1};  os = sel1; od = od1; ov = ov1; end
      default: begin og = g2;          os = sel2; od = od2; ov = ov2; end
    endcase
    r  = req_of(k);
    eg = m_busy[k] ? 4'(1 << m_sel[k]) : 4'd0;
    ev = m_busy[k] && r[m_sel[k]];
    ed = m_busy[k] ? data_of(k, m_sel[k]) : 8'd0;
    n_tests++;
    if (og !== eg) begin
      n_fail++;
      $display("FAIL gnt inst%0d cyc%0d: got %b expected %b", k, cyc, og, eg);
    end
    n_tests++;
    if (ov !== ev) begin
      n_fail++;
      $display("FAIL out_valid inst%0d cyc%0d: got %b expected %b", k, cyc, ov, ev);
    end
    n_tests++;
    if (od !== ed) begin
      n_fail++;
      $display("FAIL out_data inst%0d cyc%0d: got %h expected %h", k, cyc, od, ed);
    end
    if (m_busy[k]) begin
      n_tests++;
      if (os !== 2'(m_sel[k])) begin
        n_fail++;
        $display("FAIL out_sel inst%0d cyc%0d: got %0d expected %0d", k, cyc, os, m_sel[k]);
      end
    end
  endtask

  // Compare at the falling edge, then let the rising edge advance DUT and model.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_inst(k);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    req0 = '0; req1 = '0; req2 = '0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (g0 !== 4'b0000 || ov0 !== 1'b0 || od0 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b valid=%b data=%h expected 0000/0/00", g0, ov0, od0);
    end
    req0 = 4'b0010; rdy0 = 1'b0;
    tick();
    n_tests++;
    if (g0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL grant_latency: got %b expected 0010", g0);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (g0 !== 4'b0000 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got gnt=%b valid=%b expected 0000/0", g0, ov0);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (g0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL regrant_after_reset: got %b expected 0010", g0);
    end
    // Move the pointer to 1, then show reset returns the search start to 0.
    req0 = 4'b0000; tick();
    req0 = 4'b0001; tick();
    req0 = 4'b0000; tick();
    req0 = 4'b0011; rst = 1'b1; tick();
    rst = 1'b0; tick();
    n_tests++;
    if (g0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_ptr: got %b expected 0001", g0);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    glog0.delete();
    req0 = 4'b1111;
    for (int i = 0; i < 25; i++) tick();
    n_tests++;
    if (glog0.size() < 5) begin
      n_fail++;
      $display("FAIL rotation_count: got %0d grants expected 5", glog0.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (glog0[i] != (i % 4)) begin
          n_fail++;
          $display("FAIL rotation_order[%0d]: got %0d expected %0d", i, glog0[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req0 = 4'b0100;
    tick();
    tick(); tick();
    req0 = 4'b0000;
    tick();
    n_tests++;
    if (g0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL early_release: got %b expected 0000", g0);
    end
    req0 = 4'b0110;
    tick();
    n_tests++;
    if (g0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL ptr_after_release: got %b expected 0010", g0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    data0 = 32'h0;
    data0[15:8] = 8'hA5;
    req0 = 4'b0010; rdy0 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (od0 !== 8'hA5 || ov0 !== 1'b1 || g0 !== 4'b0010) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got data=%h valid=%b gnt=%b expected a5/1/0010", i, od0, ov0, g0);
      end
    end
    rdy0 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (g0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_count_3beats: got %b expected 0010", g0);
    end
    tick();
    n_tests++;
    if (g0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_count_4beats: got %b expected 0000", g0);
    end
  endtask

  task automatic test_wrap_np2();
    do_reset();
    req1 = 3'b010; tick();
    req1 = 3'b000; tick();
    req1 = 3'b101;
    glog1.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (sel1 === 2'd3) begin
        n_fail++;
        $display("FAIL wrap_sel_range: got %0d expected <3", sel1);
      end
    end
    n_tests++;
    if (glog1.size() < 4) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d grants expected 4", glog1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (glog1[i] != ((i % 2 == 0) ? 2 : 0)) begin
          n_fail++;
          $display("FAIL wrap_order[%0d]: got %0d expected %0d", i, glog1[i], (i % 2 == 0) ? 2 : 0);
        end
      end
    end
  endtask

  task automatic test_sole_regrant();
    logic [3:0] exp_g;
    do_reset();
    req2 = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_g = (i % 2 == 1) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (g2 !== exp_g) begin
        n_fail++;
        $display("FAIL sole_alternate[%0d]: got %b expected %b", i, g2, exp_g);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req2 = 4'($urandom_range(0, 15));
      data0 = $urandom();
      data1 = 24'($urandom());
      data2 = $urandom();
      rdy0 = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 3) != 0);
      rdy2 = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    data0 = 32'h4433_2211;
    data1 = 24'h77_6655;
    data2 = 32'hDDCC_BBAA;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    test_reset();
    test_rotation();
    test_early_release();
    test_backpressure();
    test_wrap_np2();
    test_sole_regrant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
